pipe_execute2_stage: RTL and testbench

//  Second execute stage. Consumes the E1->E2 pipeline register outputs: forwards operands, runs ALU,

---
 rtl/pipe_execute2_stage.sv | 204 ++++++++++++++++++++
 tb/tb_pipe_execute2_stage.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_execute2_stage.sv
// ---------------------------------------------------------------------------
// pipe_execute2_stage
//
// Second execute stage of the pipeline. It takes the E1->E2 register outputs
// and does the following:
//   - selects the forwarded operands
//   - runs the ALU
//   - resolves branches and jumps, and checks the front-end prediction
//   - drives the fetch redirect and the branch predictor update
//   - registers the results into the E2->M pipeline register, honouring
//     stall and flush
//
// Optional feature:
//   PIPE_E2_PERF_EN  when defined, builds saturating perf counters for
//                    resolved branches and mispredicts. When undefined,
//                    branch_cnt and mispred_cnt are tied to zero.
//
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   *_e2                E1->E2 register outputs (control, operands, pc,
//                       prediction)
//   fwd_a_sel/fwd_b_sel 00 rd*_e2, 01 result_w, 10 alu_result_m,
//                       11 reserved (behaves as rd*_e2)
//   alu_result_m        M-stage forward value
//   result_w            WB-stage forward value
//   stall_m, flush_m    hold / bubble the E2->M register
//   redirect_valid/pc   combinational mispredict redirect to fetch
//   bp_upd_*            combinational predictor update
//   *_m, *_m_q          registered E2->M outputs
//   branch_cnt          perf counter: resolved branches/jumps
//   mispred_cnt         perf counter: mispredicts
// ---------------------------------------------------------------------------
module pipe_execute2_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            reg_write_e2,
  input  logic [1:0]      result_src_e2,
  input  logic            mem_read_e2,
  input  logic            mem_write_e2,
  input  logic            jump_e2,
  input  logic [1:0]      branch_e2,
  input  logic [2:0]      alu_control_e2,
  input  logic            alu_src_e2,
  input  logic [XLEN-1:0] rd1_e2,
  input  logic [XLEN-1:0] rd2_e2,
  input  logic [4:0]      rd_e2,
  input  logic [XLEN-1:0] pc_e2,
  input  logic [XLEN-1:0] pc_plus4_e2,
  input  logic [XLEN-1:0] imm_ext_e2,
  input  logic            pred_taken_e2,
  input  logic [XLEN-1:0] pred_pc_e2,
  input  logic [1:0]      fwd_a_sel,
  input  logic [1:0]      fwd_b_sel,
  input  logic [XLEN-1:0] alu_result_m,
  input  logic [XLEN-1:0] result_w,
  input  logic            stall_m,
  input  logic            flush_m,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic            bp_upd_valid,
  output logic [XLEN-1:0] bp_upd_pc,
  output logic [XLEN-1:0] bp_upd_target,
  output logic            bp_upd_taken,
  output logic            reg_write_m,
  output logic [1:0]      result_src_m,
  output logic            mem_read_m,
  output logic            mem_write_m,
  output logic [4:0]      rd_m,
  output logic [XLEN-1:0] alu_result_m_q,
  output logic [XLEN-1:0] write_data_m,
  output logic [XLEN-1:0] pc_plus4_m,
  output logic [XLEN-1:0] branch_cnt,
  output logic [XLEN-1:0] mispred_cnt
);

  logic [XLEN-1:0] src_a;
  logic [XLEN-1:0] fwd_b;
  logic [XLEN-1:0] src_b;
  logic [XLEN-1:0] alu_result;
  logic [XLEN-1:0] target;
  logic            branch_cond;
  logic            actual_taken;
  logic            is_bubble;
  logic            mispredict;

  // Operand forwarding. The reserved select (11) falls back to the register
  // file value.
  always_comb begin
    src_a = rd1_e2;
    fwd_b = rd2_e2;
    case (fwd_a_sel)
      2'b01:   src_a = result_w;
      2'b10:   src_a = alu_result_m;
      default: src_a = rd1_e2;
    endcase
    case (fwd_b_sel)
      2'b01:   fwd_b = result_w;
      2'b10:   fwd_b = alu_result_m;
      default: fwd_b = rd2_e2;
    endcase
  end

  assign src_b = alu_src_e2 ? imm_ext_e2 : fwd_b;

  // ALU. Shift amounts use only the low five bits of operand B.
  always_comb begin
    alu_result = '0;
    case (alu_control_e2)
      3'b000: alu_result = src_a + src_b;
      3'b001: alu_result = src_a - src_b;
      3'b010: alu_result = src_a & src_b;
      3'b011: alu_result = src_a | src_b;
      3'b100: alu_result = src_a ^ src_b;
      3'b101: alu_result = {{(XLEN-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
      3'b110: alu_result = src_a << src_b[4:0];
      default: alu_result = src_a >> src_b[4:0];
    endcase
  end

  // Branch condition. The comparison always uses the forwarded register
  // operands, never the immediate.
  always_comb begin
    branch_cond = 1'b0;
    case (branch_e2)
      2'b01:   branch_cond = (src_a == fwd_b);
      2'b10:   branch_cond = (src_a != fwd_b);
      2'b11:   branch_cond = ($signed(src_a) < $signed(fwd_b));
      default: branch_cond = 1'b0;
    endcase
  end

  // jalr computes its target from register A and clears bit 0.
  // Every other branch or jump is pc-relative.
  assign target = (jump_e2 && alu_src_e2) ? ((src_a + imm_ext_e2) & ~{{(XLEN-1){1'b0}}, 1'b1})
                                          : (pc_e2 + imm_ext_e2);

  assign actual_taken = jump_e2 | branch_cond;

  // A bubble has every control field at zero. Whatever prediction bits come
  // along with a bubble are stale and must not cause a redirect.
  assign is_bubble = ~(reg_write_e2 | (|result_src_e2) | mem_read_e2 | mem_write_e2 |
                       jump_e2 | (|branch_e2) | (|alu_control_e2) | alu_src_e2);

  assign mispredict = ~is_bubble &
                      (actual_taken ? (~pred_taken_e2 | (pred_pc_e2 != target))
                                    : pred_taken_e2);

  // Strobes are gated by stall_m. A stalled instruction stays in E2, so it
  // reports only in the cycle it actually advances.
  assign redirect_valid = mispredict & ~stall_m;
  assign redirect_pc    = actual_taken ? target : pc_plus4_e2;
  assign bp_upd_valid   = ((|branch_e2) | jump_e2) & ~stall_m;
  assign bp_upd_pc      = pc_e2;
  assign bp_upd_target  = target;
  assign bp_upd_taken   = actual_taken;

  // E2->M register. Priority is reset, then flush, then stall, then load.
  // A flush that arrives together with a stall still inserts a bubble.
  always_ff @(posedge clk) begin
    if (rst || flush_m) begin
      reg_write_m    <= 1'b0;
      result_src_m   <= 2'b00;
      mem_read_m     <= 1'b0;
      mem_write_m    <= 1'b0;
      rd_m           <= 5'd0;
      alu_result_m_q <= '0;
      write_data_m   <= '0;
      pc_plus4_m     <= '0;
    end else if (!stall_m) begin
      reg_write_m    <= reg_write_e2;
      result_src_m   <= result_src_e2;
      mem_read_m     <= mem_read_e2;
      mem_write_m    <= mem_write_e2;
      rd_m           <= rd_e2;
      alu_result_m_q <= alu_result;
      write_data_m   <= fwd_b;
      pc_plus4_m     <= pc_plus4_e2;
    end
  end

`ifdef PIPE_E2_PERF_EN
  // Perf counters. They count the same strobes the predictor and fetch see,
  // saturate at all ones, and are cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      branch_cnt  <= '0;
      mispred_cnt <= '0;
    end else begin
      if (bp_upd_valid && (branch_cnt != {XLEN{1'b1}})) begin
        branch_cnt <= branch_cnt + 1'b1;
      end
      if (redirect_valid && (mispred_cnt != {XLEN{1'b1}})) begin
        mispred_cnt <= mispred_cnt + 1'b1;
      end
    end
  end
`else
  assign branch_cnt  = '0;
  assign mispred_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_execute2_stage.sv
// ---------------------------------------------------------------------------
// tb_pipe_execute2_stage
//
// Scoreboard bench for pipe_execute2_stage.
//
// The driver issues one stimulus per cycle. For each one it computes two
// expectations from a behavioural model and pushes them onto queues:
//   - the combinational response (checked in the same cycle)
//   - the E2->M register contents (checked in the following cycle)
// A separate monitor pops and compares both queues on every falling edge.
//
// Define PIPE_E2_PERF_EN to check the perf counters as well.
// ---------------------------------------------------------------------------
module tb_pipe_execute2_stage;

  typedef struct {
    logic        rst, stall, flush;
    logic        reg_write;
    logic [1:0]  result_src;
    logic        mem_read, mem_write, jump;
    logic [1:0]  branch;
    logic [2:0]  alu_control;
    logic        alu_src;
    logic [31:0] rd1, rd2;
    logic [4:0]  rd;
    logic [31:0] pc, pc4, imm;
    logic        pred_taken;
    logic [31:0] pred_pc;
    logic [1:0]  fa, fb;
    logic [31:0] alu_m, res_w;
  } stim_t;

  typedef struct {
    int          cyc;
    logic        rv;
    logic [31:0] rpc;
    logic        bv;
    logic [31:0] bpc, btgt;
    logic        btk;
  } comb_t;

  typedef struct {
    int          cyc;
    logic        reg_write;
    logic [1:0]  result_src;
    logic        mem_read, mem_write;
    logic [4:0]  rd;
    logic [31:0] alu, wd, pc4, bcnt, mcnt;
  } mreg_t;

  logic clk = 1'b0;
  logic rst;
  logic reg_write_e2, mem_read_e2, mem_write_e2, jump_e2, alu_src_e2, pred_taken_e2;
  logic [1:0] result_src_e2, branch_e2, fwd_a_sel, fwd_b_sel;
  logic [2:0] alu_control_e2;
  logic [31:0] rd1_e2, rd2_e2, pc_e2, pc_plus4_e2, imm_ext_e2, pred_pc_e2;
  logic [4:0] rd_e2;
  logic [31:0] alu_result_m, result_w;
  logic stall_m, flush_m;
  logic redirect_valid, bp_upd_valid, bp_upd_taken;
  logic [31:0] redirect_pc, bp_upd_pc, bp_upd_target;
  logic reg_write_m, mem_read_m, mem_write_m;
  logic [1:0] result_src_m;
  logic [4:0] rd_m;
  logic [31:0] alu_result_m_q, write_data_m, pc_plus4_m, branch_cnt, mispred_cnt;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  comb_t combQ[$];
  mreg_t regQ[$];
  mreg_t mstate;

  pipe_execute2_stage #(.XLEN(32)) dut (
    .clk(clk), .rst(rst),
    .reg_write_e2(reg_write_e2), .result_src_e2(result_src_e2),
    .mem_read_e2(mem_read_e2), .mem_write_e2(mem_write_e2),
    .jump_e2(jump_e2), .branch_e2(branch_e2), .alu_control_e2(alu_control_e2),
    .alu_src_e2(alu_src_e2), .rd1_e2(rd1_e2), .rd2_e2(rd2_e2), .rd_e2(rd_e2),
    .pc_e2(pc_e2), .pc_plus4_e2(pc_plus4_e2), .imm_ext_e2(imm_ext_e2),
    .pred_taken_e2(pred_taken_e2), .pred_pc_e2(pred_pc_e2),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
    .alu_result_m(alu_result_m), .result_w(result_w),
    .stall_m(stall_m), .flush_m(flush_m),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .bp_upd_valid(bp_upd_valid), .bp_upd_pc(bp_upd_pc),
    .bp_upd_target(bp_upd_target), .bp_upd_taken(bp_upd_taken),
    .reg_write_m(reg_write_m), .result_src_m(result_src_m),
    .mem_read_m(mem_read_m), .mem_write_m(mem_write_m), .rd_m(rd_m),
    .alu_result_m_q(alu_result_m_q), .write_data_m(write_data_m),
    .pc_plus4_m(pc_plus4_m), .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
  );

  // Free-running clock. The cycle index is stamped on every rising edge.
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic stim_t bubble();
    stim_t s;
    s = '{default: '0};
    return s;
  endfunction

  function automatic logic [31:0] pick(input logic [1:0] sel, input logic [31:0] base,
                                       input logic [31:0] w, input logic [31:0] m);
    if (sel == 2'b01) return w;
    if (sel == 2'b10) return m;
    return base;
  endfunction

  // Reference behaviour of one instruction, written directly from the
  // instruction semantics.
  function automatic void model(input stim_t s, output comb_t c,
                                output logic [31:0] alu, output logic [31:0] wd);
    logic [31:0] a, bf, b, tgt;
    logic taken, cf, ctl, mis;
    a  = pick(s.fa, s.rd1, s.res_w, s.alu_m);
    bf = pick(s.fb, s.rd2, s.res_w, s.alu_m);
    b  = s.alu_src ? s.imm : bf;
    case (s.alu_control)
      3'd0: alu = a + b;
      3'd1: alu = a - b;
      3'd2: alu = a & b;
      3'd3: alu = a | b;
      3'd4: alu = a ^ b;
      3'd5: alu = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd6: alu = a << b[4:0];
      default: alu = a >> b[4:0];
    endcase
    wd = bf;
    taken = s.jump || (s.branch == 2'd1 && a == bf) || (s.branch == 2'd2 && a != bf) ||
            (s.branch == 2'd3 && $signed(a) < $signed(bf));
    tgt = (s.jump && s.alu_src) ? ((a + s.imm) & 32'hFFFF_FFFE) : (s.pc + s.imm);
    cf  = s.jump || (s.branch != 2'd0);
    ctl = s.reg_write || s.result_src != 0 || s.mem_read || s.mem_write || cf ||
          s.alu_control != 0 || s.alu_src;
    mis = ctl && (taken ? (!s.pred_taken || s.pred_pc != tgt) : s.pred_taken);
    c.cyc  = 0;
    c.rv   = mis && !s.stall;
    c.rpc  = taken ? tgt : s.pc4;
    c.bv   = cf && !s.stall;
    c.bpc  = s.pc;
    c.btgt = tgt;
    c.btk  = taken;
  endfunction

  // Drive one stimulus just after the rising edge, then push its expected
  // combinational response and the expected register state after the next
  // edge.
  task automatic applyStimulus(input stim_t s);
    comb_t c;
    logic [31:0] alu, wd;
    @(posedge clk);
    #1;
    rst = s.rst; stall_m = s.stall; flush_m = s.flush;
    reg_write_e2 = s.reg_write; result_src_e2 = s.result_src;
    mem_read_e2 = s.mem_read; mem_write_e2 = s.mem_write; jump_e2 = s.jump;
    branch_e2 = s.branch; alu_control_e2 = s.alu_control; alu_src_e2 = s.alu_src;
    rd1_e2 = s.rd1; rd2_e2 = s.rd2; rd_e2 = s.rd; pc_e2 = s.pc; pc_plus4_e2 = s.pc4;
    imm_ext_e2 = s.imm; pred_taken_e2 = s.pred_taken; pred_pc_e2 = s.pred_pc;
    fwd_a_sel = s.fa; fwd_b_sel = s.fb; alu_result_m = s.alu_m; result_w = s.res_w;
    model(s, c, alu, wd);
    c.cyc = cyc;
    combQ.push_back(c);
    if (s.rst) begin
      mstate = '{default: '0};
    end else begin
`ifdef PIPE_E2_PERF_EN
      if (c.bv && mstate.bcnt != 32'hFFFF_FFFF) mstate.bcnt++;
      if (c.rv && mstate.mcnt != 32'hFFFF_FFFF) mstate.mcnt++;
`endif
      if (s.flush) begin
        mstate.reg_write = 0; mstate.result_src = 0; mstate.mem_read = 0;
        mstate.mem_write = 0; mstate.rd = 0; mstate.alu = 0; mstate.wd = 0; mstate.pc4 = 0;
      end else if (!s.stall) begin
        mstate.reg_write = s.reg_write; mstate.result_src = s.result_src;
        mstate.mem_read = s.mem_read; mstate.mem_write = s.mem_write; mstate.rd = s.rd;
        mstate.alu = alu; mstate.wd = wd; mstate.pc4 = s.pc4;
      end
    end
    mstate.cyc = cyc + 1;
    regQ.push_back(mstate);
  endtask

  function automatic stim_t randStim();
    stim_t s;
    comb_t c;
    logic [31:0] alu, wd;
    s.rst = ($urandom_range(0, 49) == 0);
    s.stall = ($urandom_range(0, 4) == 0);
    s.flush = ($urandom_range(0, 7) == 0);
    s.reg_write = 1'($urandom); s.result_src = 2'($urandom);
    s.mem_read = 1'($urandom); s.mem_write = 1'($urandom);
    s.jump = ($urandom_range(0, 5) == 0);
    s.branch = 2'($urandom); s.alu_control = 3'($urandom); s.alu_src = 1'($urandom);
    s.rd1 = $urandom;
    s.rd2 = ($urandom_range(0, 2) == 0) ? s.rd1 : $urandom;
    s.rd = 5'($urandom);
    s.pc = $urandom & 32'hFFFF_FFFC; s.pc4 = s.pc + 4;
    s.imm = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 4095)) : $urandom;
    s.fa = 2'($urandom); s.fb = 2'($urandom);
    s.alu_m = $urandom; s.res_w = $urandom;
    s.pred_taken = 1'($urandom);
    s.pred_pc = 32'h0;
    model(s, c, alu, wd);
    s.pred_pc = ($urandom_range(0, 1) == 0) ? c.btgt : $urandom;
    return s;
  endfunction

  // Monitor: compares whatever the scoreboard expects for the current cycle,
  // sampling mid-cycle away from the rising edge.
  initial begin
    comb_t c;
    mreg_t m;
    forever begin
      @(negedge clk);
      if (combQ.size() > 0 && combQ[0].cyc == cyc) begin
        c = combQ.pop_front();
        checkOutput("redirect_valid", 32'(redirect_valid), 32'(c.rv));
        if (c.rv) checkOutput("redirect_pc", redirect_pc, c.rpc);
        checkOutput("bp_upd_valid", 32'(bp_upd_valid), 32'(c.bv));
        if (c.bv) begin
          checkOutput("bp_upd_pc", bp_upd_pc, c.bpc);
          checkOutput("bp_upd_target", bp_upd_target, c.btgt);
          checkOutput("bp_upd_taken", 32'(bp_upd_taken), 32'(c.btk));
        end
      end
      if (regQ.size() > 0 && regQ[0].cyc == cyc) begin
        m = regQ.pop_front();
        checkOutput("reg_write_m", 32'(reg_write_m), 32'(m.reg_write));
        checkOutput("result_src_m", 32'(result_src_m), 32'(m.result_src));
        checkOutput("mem_read_m", 32'(mem_read_m), 32'(m.mem_read));
        checkOutput("mem_write_m", 32'(mem_write_m), 32'(m.mem_write));
        checkOutput("rd_m", 32'(rd_m), 32'(m.rd));
        checkOutput("alu_result_m_q", alu_result_m_q, m.alu);
        checkOutput("write_data_m", write_data_m, m.wd);
        checkOutput("pc_plus4_m", pc_plus4_m, m.pc4);
        checkOutput("branch_cnt", branch_cnt, m.bcnt);
        checkOutput("mispred_cnt", mispred_cnt, m.mcnt);
      end
    end
  end

  // Directed scenarios first, then a randomized run.
  initial begin
    stim_t s;
    mstate = '{default: '0};
    rst = 1'b1; stall_m = 0; flush_m = 0;
    reg_write_e2 = 0; result_src_e2 = 0; mem_read_e2 = 0; mem_write_e2 = 0; jump_e2 = 0;
    branch_e2 = 0; alu_control_e2 = 0; alu_src_e2 = 0; rd1_e2 = 0; rd2_e2 = 0; rd_e2 = 0;
    pc_e2 = 0; pc_plus4_e2 = 0; imm_ext_e2 = 0; pred_taken_e2 = 0; pred_pc_e2 = 0;
    fwd_a_sel = 0; fwd_b_sel = 0; alu_result_m = 0; result_w = 0;

    s = bubble(); s.rst = 1;
    applyStimulus(s);
    applyStimulus(s);

    // add 5 + 7
    s = bubble(); s.reg_write = 1; s.rd1 = 5; s.rd2 = 7; s.rd = 5'd9; s.pc4 = 32'h54;
    applyStimulus(s);
    s = bubble();
    applyStimulus(s);
    #1;
    checkOutput("t1_alu_result", alu_result_m_q, 32'd12);
    checkOutput("t1_reg_write", 32'(reg_write_m), 32'd1);
    checkOutput("t1_rd", 32'(rd_m), 32'd9);

    // beq taken, predicted not taken
    s = bubble(); s.branch = 2'd1; s.rd1 = 32'h33; s.rd2 = 32'h33;
    s.pc = 32'h100; s.pc4 = 32'h104; s.imm = 32'h20;
    applyStimulus(s);
    #1;
    checkOutput("t2_redirect_valid", 32'(redirect_valid), 32'd1);
    checkOutput("t2_redirect_pc", redirect_pc, 32'h120);
    checkOutput("t2_bp_taken", 32'(bp_upd_taken), 32'd1);

    // bne with equal operands
    s.branch = 2'd2; s.pred_taken = 1;
    applyStimulus(s);
    #1;
    checkOutput("t3_redirect_pc", redirect_pc, 32'h104);
    s.pred_taken = 0;
    applyStimulus(s);
    #1;
    checkOutput("t3_no_redirect", 32'(redirect_valid), 32'd0);

    // jalr
    s = bubble(); s.jump = 1; s.alu_src = 1; s.reg_write = 1; s.rd = 5'd1;
    s.rd1 = 32'h203; s.imm = 32'h4; s.pc = 32'h300; s.pc4 = 32'h304;
    s.pred_taken = 1; s.pred_pc = 32'h206;
    applyStimulus(s);
    #1;
    checkOutput("t4_target", bp_upd_target, 32'h206);
    checkOutput("t4_no_redirect", 32'(redirect_valid), 32'd0);
    s.pred_pc = 32'h200;
    applyStimulus(s);
    #1;
    checkOutput("t4_redirect_pc", redirect_pc, 32'h206);

    // slt with forwarded -1 from M, then a 3-cycle stall, then flush+stall
    s = bubble(); s.reg_write = 1; s.alu_control = 3'd5; s.fa = 2'b10;
    s.alu_m = 32'hFFFF_FFFF; s.rd2 = 0; s.rd = 5'd4;
    applyStimulus(s);
    for (int i = 0; i < 3; i++) begin
      s = randStim(); s.rst = 0; s.flush = 0; s.stall = 1;
      applyStimulus(s);
      #1;
      checkOutput("t5_hold_alu", alu_result_m_q, 32'd1);
    end
    s = randStim(); s.rst = 0; s.flush = 1; s.stall = 1;
    applyStimulus(s);
    s = bubble();
    applyStimulus(s);
    #1;
    checkOutput("t5_bubble_rw", 32'(reg_write_m), 32'd0);

    // four branches, two mispredicts, one of them held by a stall first
    s = bubble(); s.rst = 1;
    applyStimulus(s);
    s = bubble(); s.branch = 2'd1; s.rd1 = 1; s.rd2 = 1; s.pc = 32'h100; s.pc4 = 32'h104;
    s.imm = 32'h20; s.pred_taken = 1; s.pred_pc = 32'h120;
    applyStimulus(s);
    s.pred_taken = 0;
    applyStimulus(s);
    s.branch = 2'd2; s.pred_taken = 1; s.stall = 1;
    applyStimulus(s);
    s.stall = 0;
    applyStimulus(s);
    s.pred_taken = 0;
    applyStimulus(s);
    s = bubble();
    applyStimulus(s);
    #1;
`ifdef PIPE_E2_PERF_EN
    checkOutput("t6_branch_cnt", branch_cnt, 32'd4);
    checkOutput("t6_mispred_cnt", mispred_cnt, 32'd2);
`else
    checkOutput("t6_branch_cnt_off", branch_cnt, 32'd0);
    checkOutput("t6_mispred_cnt_off", mispred_cnt, 32'd0);
`endif
    s = bubble(); s.rst = 1;
    applyStimulus(s);
    s = bubble();
    applyStimulus(s);
    #1;
    checkOutput("t6_cnt_reset", branch_cnt | mispred_cnt, 32'd0);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      applyStimulus(randStim());
    end
    s = bubble();
    applyStimulus(s);
    @(negedge clk);
    @(negedge clk);
    checkOutput("queue_drain", 32'(combQ.size() + regQ.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
